// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared state encodings, widths and helpers for the write-port arbiter
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// rtl/regfile_wb_arbiter_wb_scoreboard.sv - busy bits for registers awaiting a mul/div result
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_idx_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_idx_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  rd_busy_o,
  output logic [NUM_REGS-1:0]   busy_vec_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear first, then set, so a same-cycle issue to the retiring index keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d = busy_d & ~reg_onehot(clr_idx_i);
    if (set_en_i) busy_d = busy_d | reg_onehot(set_idx_i);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign rs1_busy_o = busy_q[rs1_i];
  assign rs2_busy_o = busy_q[rs2_i];
  assign rd_busy_o  = busy_q[rd_i];
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with mul/div scoreboard; REGFILE_BYPASS_EN adds operand bypass
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_wr_addr,
  input  logic [XLEN-1:0]       wb_wr_data,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]       md_data,
  output logic                  md_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_rd_wr,
  input  logic [XLEN-1:0]       dec_op1_in,
  input  logic [XLEN-1:0]       dec_op2_in,
  output logic [XLEN-1:0]       dec_op1,
  output logic [XLEN-1:0]       dec_op2,
  output logic                  dec_stall,
  output logic                  pipe_hold,
  output logic                  reg_file_wr_en,
  output logic [REG_ADDR_W-1:0] reg_file_wr_addr,
  output logic [XLEN-1:0]       reg_file_wr_data,
  output logic [NUM_REGS-1:0]   busy_vec
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wb_gnt, md_gnt;
  logic             rs1_busy, rs2_busy, rd_busy, byp1, byp2;

  assign pipe_hold = (state_q == HOLD);

  // Writes to x0 are architectural no-ops, so they never take the port from mul/div.
  assign wb_gnt = rst && wb_wr_en && (wb_wr_addr != '0) && !pipe_hold;
  assign md_gnt = rst && md_valid && !wb_gnt;

  assign md_ready         = md_gnt;
  assign reg_file_wr_en   = wb_gnt || (md_gnt && (md_rd != '0));
  assign reg_file_wr_addr = wb_gnt ? wb_wr_addr : md_rd;
  assign reg_file_wr_data = wb_gnt ? wb_wr_data : md_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_valid && !md_gnt) begin
            state_q <= (MAX_WAIT_C == CNT_W'(1)) ? HOLD : WAIT;
            cnt_q   <= (MAX_WAIT_C == CNT_W'(1)) ? '0 : CNT_W'(1);
          end
        end
        WAIT: begin
          if (!md_valid || md_gnt) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q + CNT_W'(1) == MAX_WAIT_C) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_ni     (rst),
    .set_en_i   (issue_valid && (issue_rd != '0)),
    .set_idx_i  (issue_rd),
    .clr_en_i   (md_gnt),
    .clr_idx_i  (md_rd),
    .rs1_i      (dec_rs1),
    .rs2_i      (dec_rs2),
    .rd_i       (dec_rd),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy),
    .busy_vec_o (busy_vec)
  );

`ifdef REGFILE_BYPASS_EN
  assign byp1 = reg_file_wr_en && (reg_file_wr_addr == dec_rs1) && (dec_rs1 != '0);
  assign byp2 = reg_file_wr_en && (reg_file_wr_addr == dec_rs2) && (dec_rs2 != '0);
  assign dec_op1 = byp1 ? reg_file_wr_data : dec_op1_in;
  assign dec_op2 = byp2 ? reg_file_wr_data : dec_op2_in;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign dec_op1 = dec_op1_in;
  assign dec_op2 = dec_op2_in;
`endif

  // A bypassed source is satisfied this cycle, so its busy bit must not stall decode.
  assign dec_stall = rst && ((rs1_busy && !byp1) || (rs2_busy && !byp2) ||
                             (dec_rd_wr && rd_busy) || pipe_hold);

endmodule
